// File: rtl/ysyx_23060208_ifu.sv
// rtl/ysyx_23060208_ifu.sv - instruction fetch unit: one AXI4 single-beat read per instruction,
// hands {pc, inst} to the IDU and waits for the EXU's next-pc before fetching again.
module ysyx_23060208_ifu #(
    parameter int                  DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h3000_0000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DATA_WIDTH:0]       exu_to_ifu_bus,
    input  logic                      exu_to_ifu_valid,
    output logic                      isram_arvalid,
    input  logic                      isram_arready,
    output logic [DATA_WIDTH-1:0]     isram_araddr,
    output logic [3:0]                isram_arid,
    output logic [7:0]                isram_arlen,
    output logic [2:0]                isram_arsize,
    output logic [1:0]                isram_arburst,
    input  logic                      isram_rvalid,
    output logic                      isram_rready,
    input  logic [63:0]               isram_rdata,
    input  logic [1:0]                isram_rresp,
    input  logic                      isram_rlast,
    input  logic [3:0]                isram_rid,
    output logic [2*DATA_WIDTH-1:0]   ifu_to_idu_bus,
    output logic                      ifu_to_idu_valid,
    input  logic                      idu_allowin,
    output logic                      ifu_fault
);

    typedef enum logic [2:0] {
        S_BOOT     = 3'd0,
        S_FETCH_AR = 3'd1,
        S_FETCH_R  = 3'd2,
        S_SEND     = 3'd3,
        S_WAIT_NPC = 3'd4
    } state_e;

    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

    state_e                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     pc_q, pc_d;
    logic                      pend_q, pend_d;
    logic [DATA_WIDTH:0]       pend_bus_q, pend_bus_d;
    logic [3:0]                cnt_q;
    logic [3:0]                arid_q, arid_d;
    logic                      arvalid_q, arvalid_d;
    logic                      rready_q, rready_d;
    logic [2*DATA_WIDTH-1:0]   bus_q, bus_d;
    logic                      valid_q, valid_d;
    logic                      fault_q, fault_d;

    logic                      r_accept;
    logic                      npc_avail;
    logic [DATA_WIDTH:0]       npc_bus;
    logic [31:0]               inst;
    logic                      unused_rlast;

    // Bursts are always one beat long, so rlast carries no information.
    assign unused_rlast = isram_rlast;

    assign r_accept  = (state_q == S_FETCH_R) && isram_rvalid && (isram_rid == arid_q);
    assign npc_avail = exu_to_ifu_valid || pend_q;
    assign npc_bus   = exu_to_ifu_valid ? exu_to_ifu_bus : pend_bus_q;
    assign inst      = pc_q[2] ? isram_rdata[63:32] : isram_rdata[31:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_bus_q <= '0;
            cnt_q      <= 4'd0;
            arid_q     <= 4'd0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            bus_q      <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_bus_q <= pend_bus_d;
            cnt_q      <= cnt_q + 4'd1;
            arid_q     <= arid_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            bus_q      <= bus_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:     state_d = S_FETCH_AR;
            S_FETCH_AR: if (isram_arready) state_d = S_FETCH_R;
            S_FETCH_R:  if (r_accept)      state_d = S_SEND;
            S_SEND:     if (idu_allowin)   state_d = S_WAIT_NPC;
            S_WAIT_NPC: if (npc_avail)     state_d = S_FETCH_AR;
            default:                       state_d = S_BOOT;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_bus_d = pend_bus_q;
        arid_d     = arid_q;
        bus_d      = bus_q;

        if (state_q == S_WAIT_NPC) begin
            pend_d = 1'b0;
            if (npc_avail)
                pc_d = npc_bus[DATA_WIDTH] ? npc_bus[DATA_WIDTH-1:0] : pc_q + PC_STEP;
        end else if (state_q != S_BOOT && exu_to_ifu_valid) begin
            // Next-pc arriving while a fetch is still in flight is parked until WAIT_NPC.
            pend_d     = 1'b1;
            pend_bus_d = exu_to_ifu_bus;
        end

        if (state_d == S_FETCH_AR && state_q != S_FETCH_AR)
            arid_d = cnt_q;

        if (r_accept)
            bus_d = {pc_q, inst};

        arvalid_d = (state_d == S_FETCH_AR);
        rready_d  = (state_d == S_FETCH_R);
        valid_d   = (state_d == S_SEND);
        fault_d   = r_accept && (isram_rresp == 2'b11);
    end

    assign isram_arvalid    = arvalid_q;
    assign isram_araddr     = pc_q;
    assign isram_arid       = arid_q;
    assign isram_arlen      = 8'h00;
    assign isram_arsize     = 3'b010;
    assign isram_arburst    = 2'b01;
    assign isram_rready     = rready_q;
    assign ifu_to_idu_bus   = bus_q;
    assign ifu_to_idu_valid = valid_q;
    assign ifu_fault        = fault_q;

endmodule
